// File: rtl/byte_unstriping_n.sv
// byte_unstriping_n: LANES per-lane FIFOs (lane_data/lane_valid in) drained round-robin to data_out/valid_out; lane_ptr, sticky overflow, sync realign
module byte_unstriping_n #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                          clk_f,
  input  logic                          reset,
  input  logic [LANES*DATA_WIDTH-1:0]   lane_data,
  input  logic [LANES-1:0]              lane_valid,
  input  logic                          sync,
  input  logic [$clog2(LANES+1)-1:0]    active_lanes,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          valid_out,
  output logic [$clog2(LANES)-1:0]      lane_ptr,
  output logic [LANES-1:0]              overflow
);
  localparam int AW = $clog2(LANES + 1);
  localparam int DW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] act;
  logic [LANES-1:0] nonempty, ovf_set;
  logic [DATA_WIDTH-1:0] head [LANES];
  logic pop_go, last;
  assign pop_go = nonempty[lane_ptr];
  assign last = AW'(lane_ptr) == act - AW'(1);
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic push, pop, full, acc;
    assign push = lane_valid[g] && AW'(g) < act;
    assign pop = pop_go && lane_ptr == ($clog2(LANES))'(g);
    assign full = cnt == CW'(DEPTH);
    assign acc = push && (!full || pop);
    assign nonempty[g] = cnt != '0;
    assign head[g] = mem[rp];
    assign ovf_set[g] = push && full && !pop;
    always_ff @(posedge clk_f)
      if (!reset && !sync && acc) mem[wp] <= lane_data[g*DATA_WIDTH +: DATA_WIDTH];
    always_ff @(posedge clk_f) begin
      if (reset || sync) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        wp <= acc ? wp + DW'(1) : wp;
        rp <= pop ? rp + DW'(1) : rp;
        cnt <= cnt + CW'(acc) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk_f) begin
    if (reset) begin
      act <= AW'(LANES);
      lane_ptr <= '0;
      data_out <= '0;
      valid_out <= 1'b0;
      overflow <= '0;
    end else if (sync) begin
      act <= (active_lanes == '0 || active_lanes > AW'(LANES)) ? AW'(LANES) : active_lanes;
      lane_ptr <= '0;
      valid_out <= 1'b0;
    end else begin
      overflow <= overflow | ovf_set;
      valid_out <= pop_go;
      data_out <= pop_go ? head[lane_ptr] : data_out;
      lane_ptr <= pop_go ? (last ? '0 : lane_ptr + 1'b1) : lane_ptr;
    end
  end
endmodule
